pma_lookup_sched: RTL and testbench
===================================

# pma_lookup_sched

Shared, sequential PMA region-lookup engine that time-multiplexes one 65-bit range comparator between several requesters, e.g. the frontend fetch path and the LSU. It holds a programmable rule table: base, length and a 4-bit attribute per rule. Each lookup walks the table one rule per cycle and returns the attributes that match. It replaces per-requester parallel comparator banks in area-constrained CVA6 configurations.

## Interface
- NrRequesters, 2, number of lookup requesters (≥1)
- NrRules, 16, rule-table entries (≤16, matches the core's maximum rule count)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_we_i  in  1  rule-table write strobe
- cfg_idx_i  in  $clog2(NrRules)  rule index written
- cfg_base_i  in  64  rule base address
- cfg_len_i  in  64  rule length in bytes; 0 disables the rule
- cfg_attr_i  in  4  {shared, cached, execute, nonidempotent}
- req_valid_i  in  NrRequesters  lookup request per requester
- req_addr_i  in  NrRequesters×64  lookup address per requester
- req_ready_o  out  NrRequesters  one-hot grant; request accepted when valid&ready
- rsp_valid_o  out  1  lookup result valid
- rsp_id_o  out  $clog2(NrRequesters) (min 1)  index of the requester that owns the result
- rsp_attr_o  out  4  resulting attributes
- rsp_ready_i  in  1  result consumer ready
- busy_o  out  1  high in SCAN or RESP

## Operation
- Rule table: NrRules × {base[63:0], len[63:0], attr[3:0]}.
  - Reset clears all fields to 0.
  - A write on cfg_we_i updates entry cfg_idx_i at the clock edge. Writes are legal in any state.
- Match rule: (addr ≥ base) && ({1'b0,addr} < 65'(base)+len), computed in 65 bits so base+len never wraps. A rule with len=0 never matches.
- FSM states IDLE, SCAN, RESP; reset state is IDLE.
- IDLE:
  - If any req_valid_i is set, round-robin grants one requester. Search starts at pointer rr; rr resets to 0.
  - req_ready_o[g]=1 combinationally in the same cycle.
  - At the edge: latch addr and id, set idx=0, acc=0, set rr=(g+1) mod NrRequesters, go to SCAN.
  - req_ready_o is 0 in all other states.
- SCAN:
  - Each cycle evaluates rule idx against the table contents present in that cycle. On a match, acc |= attr.
  - idx increments each cycle. When idx==NrRules-1, go to RESP after that evaluation.
  - A config write to an already-scanned index does not affect the current lookup.
- RESP:
  - rsp_valid_o=1, rsp_attr_o=acc, rsp_id_o=latched id. All three are held stable until rsp_ready_i.
  - On valid&ready, go to IDLE.
  - No new grant happens in the handshake cycle.
- Requester-side rule: a requester keeps valid and addr stable until it is granted. Dropping valid before the grant is legal and loses no state.
- Reset mid-lookup: immediate return to IDLE, all outputs 0, rule table cleared, rr=0.

## Timing
- Reset values:
  - req_ready_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_attr_o=0, busy_o=0.
  - In IDLE after reset, req_ready_o follows the arbiter.
- Latency: grant in cycle T; rsp_valid_o rises in cycle T+NrRules+1; the earliest next grant is the cycle after the RESP handshake.
- Throughput: one lookup per NrRules+2 cycles with rsp_ready_i held high.
- rsp_* are registered. req_ready_o is combinational from req_valid_i and state; it is the only combinational path.

## Configuration
- PMA_LOOKUP_FIRST_MATCH_EN defined:
  - First-match priority. SCAN ends on the first matching rule, and rsp_attr_o = attr of the lowest-index match.
  - Latency is (k+1)+1 cycles to rsp_valid_o for a first match at index k.
  - With no match, the full scan runs and rsp_attr_o=0.
- Undefined:
  - OR of all matching rules, with a fixed full-table scan of NrRules cycles.

## Test plan
- Reset then lookup 0x8000_0000 with no rules programmed -> rsp_attr_o=0, rsp_valid_o exactly 17 cycles after grant (NrRules=16).
- Rule 3 = {base 0x8000_0000, len 0x1000, attr 4'b0110}; lookup 0x8000_0FFF -> 4'b0110; lookup 0x8000_1000 -> 4'b0000.
- Rules 1 {0x0,0x1_0000_0000,4'b0001} and 5 {0x8000_0000,0x1000,4'b0100}; lookup 0x8000_0010 -> 4'b0101 without the macro, 4'b0001 after 3 cycles with it.
- Rule {base 0xFFFF_FFFF_FFFF_F000, len 0x2000}; lookup 0xFFFF_FFFF_FFFF_FFF8 -> match (no 64-bit wrap); lookup 0x0 -> no match.
- Both requesters valid continuously with rsp_ready_i=1 -> grants alternate 0,1,0,1; rsp_id_o alternates accordingly. Holding rsp_ready_i=0 for 5 cycles keeps rsp_* stable and blocks both grants.
- Assert rst_ni low during SCAN at idx=7 -> outputs 0 immediately; after release, rule table reads as empty (next lookup returns 0).

Source files
------------

// File: rtl/pma_lookup_sched.sv
// pma_lookup_sched
//   Shared sequential PMA region lookup. A single 65-bit range comparator
//   walks the rule table one entry per cycle on behalf of one requester at
//   a time. Requesters are served round-robin.
//
// Ports
//   clk_i, rst_ni             clock, async active-low reset
//   cfg_we_i/idx/base/len/attr rule-table write port (legal in any state)
//   req_valid_i/addr_i        per-requester lookup request
//   req_ready_o               one-hot grant, combinational, IDLE only
//   rsp_valid_o/id_o/attr_o   registered lookup result, held until rsp_ready_i
//   busy_o                    high while scanning or presenting a result
//
// Build option
//   PMA_LOOKUP_FIRST_MATCH_EN: stop at the lowest-index matching rule and
//   return only its attributes. Default: OR of all matches, full-table scan.
module pma_lookup_sched #(
    parameter int unsigned NrRequesters = 2,
    parameter int unsigned NrRules      = 16,
    localparam int unsigned IdxW = (NrRules > 1) ? $clog2(NrRules) : 1,
    localparam int unsigned IdW  = (NrRequesters > 1) ? $clog2(NrRequesters) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cfg_we_i,
    input  logic [IdxW-1:0]            cfg_idx_i,
    input  logic [63:0]                cfg_base_i,
    input  logic [63:0]                cfg_len_i,
    input  logic [3:0]                 cfg_attr_i,
    input  logic [NrRequesters-1:0]    req_valid_i,
    input  logic [NrRequesters*64-1:0] req_addr_i,
    output logic [NrRequesters-1:0]    req_ready_o,
    output logic                       rsp_valid_o,
    output logic [IdW-1:0]             rsp_id_o,
    output logic [3:0]                 rsp_attr_o,
    input  logic                       rsp_ready_i,
    output logic                       busy_o
);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [63:0]       addr_q, addr_d;
    logic [IdW-1:0]    id_q, id_d;
    logic [IdW-1:0]    rr_q, rr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [3:0]        rsp_attr_q, rsp_attr_d;
`ifndef PMA_LOOKUP_FIRST_MATCH_EN
    logic [3:0]        acc_q, acc_d;
`endif

    logic [63:0] base_q [NrRules];
    logic [63:0] len_q  [NrRules];
    logic [3:0]  attr_q [NrRules];

    // Rule table: written straight from the config port; the scan reads the
    // pre-edge contents, so a write to an already-visited index is invisible.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NrRules; r++) begin
                base_q[r] <= '0;
                len_q[r]  <= '0;
                attr_q[r] <= '0;
            end
        end else if (cfg_we_i && (32'(cfg_idx_i) < NrRules)) begin
            base_q[cfg_idx_i] <= cfg_base_i;
            len_q[cfg_idx_i]  <= cfg_len_i;
            attr_q[cfg_idx_i] <= cfg_attr_i;
        end
    end

    // Round-robin arbiter: first valid requester at or after rr_q.
    logic [NrRequesters-1:0] grant;
    logic [IdW-1:0]          gnt_idx;
    logic                    found;
    int unsigned             cand;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < NrRequesters; i++) begin
            cand = 32'(rr_q) + i;
            if (cand >= NrRequesters) cand = cand - NrRequesters;
            if (!found && req_valid_i[cand]) begin
                found       = 1'b1;
                gnt_idx     = IdW'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

    // Single shared comparator; 65-bit end address so base+len cannot wrap.
    logic [63:0] cur_base, cur_len;
    logic [3:0]  cur_attr;
    logic        hit, last;

    assign cur_base = base_q[idx_q];
    assign cur_len  = len_q[idx_q];
    assign cur_attr = attr_q[idx_q];
    assign hit  = (addr_q >= cur_base) &&
                  ({1'b0, addr_q} < ({1'b0, cur_base} + {1'b0, cur_len}));
    assign last = (32'(idx_q) == NrRules - 1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        id_d        = id_q;
        rr_d        = rr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_attr_d  = rsp_attr_q;
`ifndef PMA_LOOKUP_FIRST_MATCH_EN
        acc_d       = acc_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    addr_d  = req_addr_i[gnt_idx*64 +: 64];
                    id_d    = gnt_idx;
                    idx_d   = '0;
`ifndef PMA_LOOKUP_FIRST_MATCH_EN
                    acc_d   = '0;
`endif
                    rr_d    = (32'(gnt_idx) == NrRequesters - 1) ? '0 : gnt_idx + 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                idx_d = idx_q + 1'b1;
`ifdef PMA_LOOKUP_FIRST_MATCH_EN
                if (hit || last) begin
                    rsp_attr_d  = hit ? cur_attr : 4'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
`else
                acc_d = acc_q | (hit ? cur_attr : 4'b0);
                if (last) begin
                    rsp_attr_d  = acc_d;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
`endif
            end
            RESP: begin
                // No grant in the handshake cycle: IDLE is only entered next edge.
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            addr_q      <= '0;
            id_q        <= '0;
            rr_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_attr_q  <= '0;
`ifndef PMA_LOOKUP_FIRST_MATCH_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            id_q        <= id_d;
            rr_q        <= rr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_attr_q  <= rsp_attr_d;
`ifndef PMA_LOOKUP_FIRST_MATCH_EN
            acc_q       <= acc_d;
`endif
        end
    end

    // Gated with rst_ni so the grant is silent while reset is held.
    assign req_ready_o = (rst_ni && state_q == IDLE) ? grant : '0;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_attr_o  = rsp_attr_q;
    assign rsp_id_o    = id_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_pma_lookup_sched.sv
module tb_pma_lookup_sched;

`ifdef PMA_LOOKUP_FIRST_MATCH_EN
    localparam bit FM = 1'b1;
`else
    localparam bit FM = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         cfg_we;
    logic [3:0]   cfg_idx;
    logic [63:0]  cfg_base, cfg_len;
    logic [3:0]   cfg_attr;
    logic [1:0]   req_valid;
    logic [127:0] req_addr;
    logic [1:0]   req_ready;
    logic         rsp_valid;
    logic [0:0]   rsp_id;
    logic [3:0]   rsp_attr;
    logic         rsp_ready;
    logic         busy;

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    pma_lookup_sched #(.NrRequesters(2), .NrRules(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_base_i(cfg_base),
        .cfg_len_i(cfg_len), .cfg_attr_i(cfg_attr),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_attr_o(rsp_attr),
        .rsp_ready_i(rsp_ready), .busy_o(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          rq;      // -1: rule write only
        int          widx;
        logic [63:0] base;
        logic [63:0] len;
        logic [3:0]  attr;
        logic [63:0] addr;
        logic [3:0]  exp_attr;
        int          exp_lat;
    } vec_t;

    function automatic vec_t vw(int idx, logic [63:0] b, logic [63:0] l, logic [3:0] a);
        vec_t v;
        v = '{-1, idx, b, l, a, 64'h0, 4'h0, 0};
        return v;
    endfunction

    function automatic vec_t vl(int rq, logic [63:0] ad, logic [3:0] ea, int el);
        vec_t v;
        v = '{rq, 0, 64'h0, 64'h0, 4'h0, ad, ea, el};
        return v;
    endfunction

    task automatic wr_rule(input int idx, input logic [63:0] b, input logic [63:0] l,
                           input logic [3:0] a);
        cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_base = b; cfg_len = l; cfg_attr = a;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Issue one lookup; lat counts cycles from the grant cycle to rsp_valid.
    task automatic lookup(input int rq, input logic [63:0] addr,
                          output logic [3:0] attr, output int lat, output int id);
        int n;
        req_addr[rq*64 +: 64] = addr;
        req_valid[rq] = 1'b1;
        #1;
        n = 0;
        while (req_ready[rq] !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) chk("grant_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        req_valid[rq] = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        attr = rsp_attr;
        id   = int'(rsp_id);
    endtask

    vec_t        vq[$];
    logic [3:0]  a, a0;
    int          lat, id, id0;

    initial begin
        rst_ni = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_len = '0;
        cfg_attr = '0; req_valid = 2'b11; req_addr = '0; rsp_ready = 1'b1;

        // Reset state, with requests pending
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_attr", 64'(rsp_attr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_ni = 1'b1;
        #1;
        chk("idle_arb_rr0", 64'(req_ready), 64'b01);
        req_valid = 2'b00;
        #1;
        chk("idle_no_req", 64'(req_ready), 64'd0);
        @(posedge clk); #1;

        // Directed table
        vq.push_back(vl(0, 64'h8000_0000, 4'b0000, 17));
        vq.push_back(vw(3, 64'h8000_0000, 64'h1000, 4'b0110));
        vq.push_back(vl(1, 64'h8000_0FFF, 4'b0110, FM ? 5 : 17));
        vq.push_back(vl(0, 64'h8000_1000, 4'b0000, 17));
        vq.push_back(vl(1, 64'h7FFF_FFFF, 4'b0000, 17));
        vq.push_back(vw(3, 64'h0, 64'h0, 4'b0000));
        vq.push_back(vw(1, 64'h0, 64'h1_0000_0000, 4'b0001));
        vq.push_back(vw(5, 64'h8000_0000, 64'h1000, 4'b0100));
        vq.push_back(vl(0, 64'h8000_0010, FM ? 4'b0001 : 4'b0101, FM ? 3 : 17));
        vq.push_back(vl(1, 64'h1_0000_0000, 4'b0000, 17));
        vq.push_back(vl(0, 64'hFFFF_FFFF, 4'b0001, FM ? 3 : 17));
        vq.push_back(vw(1, 64'h0, 64'h0, 4'b0000));
        vq.push_back(vw(5, 64'h0, 64'h0, 4'b0000));
        vq.push_back(vw(15, 64'hFFFF_FFFF_FFFF_F000, 64'h2000, 4'b1000));
        vq.push_back(vl(1, 64'hFFFF_FFFF_FFFF_FFF8, 4'b1000, 17));
        vq.push_back(vl(0, 64'hFFFF_FFFF_FFFF_F000, 4'b1000, 17));
        vq.push_back(vl(0, 64'h0, 4'b0000, 17));
        vq.push_back(vl(1, 64'hFFFF_FFFF_FFFF_EFFF, 4'b0000, 17));

        foreach (vq[i]) begin
            if (vq[i].rq < 0) begin
                wr_rule(vq[i].widx, vq[i].base, vq[i].len, vq[i].attr);
            end else begin
                lookup(vq[i].rq, vq[i].addr, a, lat, id);
                chk($sformatf("v%0d_attr", i), 64'(a), 64'(vq[i].exp_attr));
                chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vq[i].exp_lat));
                chk($sformatf("v%0d_id", i), 64'(id), 64'(vq[i].rq));
            end
        end

        // Reset while scanning rule 7 (rule 15 still programmed)
        @(posedge clk); #1;
        req_addr[63:0] = 64'hFFFF_FFFF_FFFF_FFF8;
        req_valid = 2'b01;
        #1;
        chk("mid_grant", 64'(req_ready), 64'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_busy", 64'(busy), 64'd1);
        req_valid = 2'b11;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_rsp_attr", 64'(rsp_attr), 64'd0);
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // Both requesters continuously valid: grants/ids alternate from rr=0,
        // second response stalled 5 cycles.
        begin
            int ng, nr, cyc;
            ng = 0; nr = 0; cyc = 0;
            req_addr = '0;
            req_valid = 2'b11;
            #1;
            while ((ng < 4 || nr < 4) && cyc < 300) begin
                if (req_ready != 2'b00) begin
                    chk($sformatf("alt_grant%0d", ng), 64'(req_ready), 64'(2'b01 << (ng % 2)));
                    ng++;
                end
                if (rsp_valid) begin
                    if (nr == 1) begin
                        rsp_ready = 1'b0;
                        a0 = rsp_attr; id0 = int'(rsp_id);
                        for (int s = 0; s < 5; s++) begin
                            @(posedge clk); #1; cyc++;
                            chk("stall_valid", 64'(rsp_valid), 64'd1);
                            chk("stall_id", 64'(rsp_id), 64'(id0));
                            chk("stall_attr", 64'(rsp_attr), 64'(a0));
                            chk("stall_nogrant", 64'(req_ready), 64'd0);
                        end
                        rsp_ready = 1'b1;
                    end
                    chk($sformatf("alt_id%0d", nr), 64'(rsp_id), 64'(nr % 2));
                    nr++;
                    if (nr == 4) req_valid = 2'b00;
                end
                @(posedge clk); #1; cyc++;
            end
            req_valid = 2'b00;
            if (cyc >= 300) chk("alt_timeout", 64'(cyc), 64'd0);
        end

        // Table must be empty after the reset
        lookup(0, 64'hFFFF_FFFF_FFFF_FFF8, a, lat, id);
        chk("post_rst_attr", 64'(a), 64'd0);
        chk("post_rst_lat", 64'(lat), 64'd17);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
